alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU. It is the WIDTH-generic successor of the 4-bit ripple ALU.
//  It keeps the {Ainvert,Binvert,Op} control encoding and adds two things:
//   - registered outputs with a start/busy/done handshake;
//   - an iterative shift-add unsigned multiplier (MUL low half, MULHU high half).
//  It sits in the execute stage and is stalled via busy while a multiply is in flight.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range >= 4.
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      operation request; sampled only when busy==0
//  alu_ctl    in   4      {ainvert,binvert,op[1:0]}; encoding listed under BEHAVIOUR
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  busy       out  1      multiply in progress; new starts are ignored
//  done       out  1      1-cycle pulse; y and flags are valid from this cycle until the next done
//  y          out  WIDTH  result
//  carry_out  out  1      adder carry (ADD/SUB/SLT), else 0
//  overflow   out  1      signed overflow (ADD/SUB), else 0
//  zero       out  1      y == 0
//  err        out  1      illegal alu_ctl; pulses together with done
// BEHAVIOUR
//  Reset (asynchronous, any time, including mid-multiply):
//   - state=IDLE; busy, done, carry_out, overflow, err = 0; y = 0; zero = 1.
//   - The in-flight operation is discarded.
//  Opcodes:
//   0000 AND    0001 OR     0010 ADD    0110 SUB (a+~b+1)
//   0111 SLT    1100 NOR    1000 MUL (low WIDTH bits of a*b)
//   1001 MULHU (high WIDTH bits of the unsigned a*b)
//   Any other code is illegal: y=0, zero=1, err=1, other flags 0, done pulses with 1-cycle latency.
//  FSM states: IDLE, MUL_RUN.
//  IDLE + start + single-cycle op (incl. illegal), start sampled at edge k:
//   - y, flags and done=1 are registered at edge k; state stays IDLE.
//  IDLE + start + MUL/MULHU at edge k:
//   - Latch a, b and the op; clear the 2*WIDTH-bit accumulator; load counter=WIDTH.
//   - busy=1 from edge k; go to MUL_RUN.
//  MUL_RUN, each edge:
//   - If mcand LSB==1, add the multiplier into the accumulator upper half (keep the carry).
//   - Shift the accumulator right by 1; decrement the counter.
//   - On the edge where the counter reaches 0 (edge k+WIDTH): write y, done=1, busy=0; go to IDLE.
//  done is high for exactly one cycle and is 0 on every other edge; y and flags hold until the next done.
//  start while busy==1 is ignored: no queueing, no effect on the running multiply.
//  start may be asserted in the same cycle done=1 (busy already 0): that start is accepted, giving back-to-back ops.
//  Arithmetic:
//   - SUB carry_out = NOT borrow.
//   - overflow = (sa==sb_eff) && (sum_msb!=sa), where sb_eff is the sign of b after the Binvert step.
//   - SLT: y = {WIDTH-1 zeros, sum_msb ^ overflow} (signed a<b); carry_out = SUB carry; overflow = 0.
//   - Logic ops, MUL and MULHU: carry_out = overflow = 0.
//  zero is always computed from the registered y.
// TESTING  (WIDTH=4)
//  1. a=1101 b=1010, one op per cycle:
//     AND -> y=1000; OR -> 1111; NOR -> 0000 with zero=1; each done 1 cycle after start.
//  2. a=1101 b=1010, ADD -> y=0111, carry_out=1, overflow=1.
//     Same operands, SUB -> y=0011, carry_out=1, overflow=0.
//  3. SLT a=1101 b=1010 -> y=0000. SLT a=1010 b=1101 -> y=0001. SLT a=0111 b=1000 -> y=0000 (positive vs negative).
//  4. MUL a=1101 b=1010 -> busy high 4 cycles, then done with y=0010.
//     MULHU same operands -> y=1000 (13*10=130).
//     A start issued mid-multiply is ignored and the result is unchanged.
//  5. Start MUL, assert rst after 2 cycles -> busy=0, y=0, zero=1, no done pulse.
//     Then ADD 0001+0001 -> y=0010.
//  6. alu_ctl=0101 -> y=0, err=1 and done=1 for one cycle.
//     MUL followed by ADD started in the done cycle -> ADD result appears on the next cycle.

Source files
------------

// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute stage and the multi-cycle ALU.
// Handshake: start is sampled only while busy==0; done pulses one cycle and y/flags hold until the next done.
interface alu_mc_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             err;

  modport master (
    output start, alu_ctl, a, b,
    input  busy, done, y, carry_out, overflow, zero, err
  );

  modport slave (
    input  start, alu_ctl, a, b,
    output busy, done, y, carry_out, overflow, zero, err
  );
endinterface

// File: rtl/alu_mc.sv
// WIDTH-generic ALU: single-cycle logic/add/sub/slt with registered results,
// plus an iterative shift-add unsigned multiplier (MUL low half, MULHU high half).
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus,
  output logic     dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   y_q;
  logic               done_q;
  logic               carry_q;
  logic               ovf_q;
  logic               err_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               hi_q;

  logic             ainv;
  logic             binv;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_w;
  logic             ovf_w;

  logic [WIDTH-1:0] res_y_d;
  logic             res_c_d;
  logic             res_v_d;
  logic             res_err_d;
  logic             is_mul_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_d;
  logic               acc_lsb_unused;

  assign ainv  = bus.alu_ctl[3];
  assign binv  = bus.alu_ctl[2];
  assign a_eff = ainv ? ~bus.a : bus.a;
  assign b_eff = binv ? ~bus.b : bus.b;
  // binvert doubles as carry-in, so SUB/SLT compute a + ~b + 1
  assign sum_w = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, binv};
  assign ovf_w = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a_eff[WIDTH-1]);

  always_comb begin
    res_y_d   = '0;
    res_c_d   = 1'b0;
    res_v_d   = 1'b0;
    res_err_d = 1'b0;
    is_mul_d  = 1'b0;
    case (bus.alu_ctl)
      4'b0000: res_y_d = a_eff & b_eff;
      4'b0001: res_y_d = a_eff | b_eff;
      4'b1100: res_y_d = a_eff & b_eff;
      4'b0010, 4'b0110: begin
        res_y_d = sum_w[WIDTH-1:0];
        res_c_d = sum_w[WIDTH];
        res_v_d = ovf_w;
      end
      4'b0111: begin
        res_y_d = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ ovf_w};
        res_c_d = sum_w[WIDTH];
      end
      4'b1000, 4'b1001: is_mul_d = 1'b1;
      default: res_err_d = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add multiplier into the upper half, then shift right.
  assign addend         = mcand_q[0] ? mplier_q : '0;
  assign upper_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_d          = {upper_sum, acc_q[WIDTH-1:1]};
  assign acc_lsb_unused = acc_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (is_mul_d) begin
              mcand_q  <= bus.a;
              mplier_q <= bus.b;
              hi_q     <= bus.alu_ctl[0];
              acc_q    <= '0;
              cnt_q    <= CW'(WIDTH);
              state_q  <= MUL_RUN;
            end else begin
              y_q     <= res_y_d;
              carry_q <= res_c_d;
              ovf_q   <= res_v_d;
              err_q   <= res_err_d;
              done_q  <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q >> 1;
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            y_q     <= hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy      = (state_q == MUL_RUN);
  assign bus.done      = done_q;
  assign bus.y         = y_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.err       = err_q;
  assign bus.zero      = (y_q == '0);
  assign dbg_state_o   = (state_q == MUL_RUN);

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=4: directed cases plus random ops checked against
// an arithmetic reference model through an expected-result queue.
module tb_alu_mc;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  int   n_vec = 0;
  int   n_err = 0;

  // {err, carry_out, overflow, y}
  logic [W+2:0] exp_q[$];

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_mul(input logic [3:0] ctl);
    return (ctl == 4'b1000) || (ctl == 4'b1001);
  endfunction

  function automatic logic [W+2:0] model(input logic [3:0] ctl, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint ua, ub, sa, sb, r, smax, smin, p;
    logic [W-1:0] y;
    logic c, v, e;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[W-1]) ? ua - (longint'(1) << W) : ua;
    sb = (b[W-1]) ? ub - (longint'(1) << W) : ub;
    smax = (longint'(1) << (W-1)) - 1;
    smin = -(longint'(1) << (W-1));
    y = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (ctl)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b1100: y = ~(a | b);
      4'b0010: begin
        y = W'(ua + ub);
        c = (ua + ub) >= (longint'(1) << W);
        r = sa + sb;
        v = (r > smax) || (r < smin);
      end
      4'b0110: begin
        y = W'(ua - ub);
        c = (ua >= ub);
        r = sa - sb;
        v = (r > smax) || (r < smin);
      end
      4'b0111: begin
        y = (sa < sb) ? W'(1) : W'(0);
        c = (ua >= ub);
      end
      4'b1000: begin
        p = ua * ub;
        y = W'(p);
      end
      4'b1001: begin
        p = ua * ub;
        y = W'(p >> W);
      end
      default: e = 1'b1;
    endcase
    return {e, c, v, y};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject);
    int lat, nbusy;
    logic [W+2:0] e;
    bus.start   = 1'b1;
    bus.alu_ctl = ctl;
    bus.a       = a;
    bus.b       = b;
    exp_q.push_back(model(ctl, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 4*W + 8) begin
      if (bus.busy) nbusy++;
      if (inject && lat == 2) begin
        bus.start   = 1'b1;
        bus.alu_ctl = 4'($urandom_range(0, 15));
        bus.a       = W'($urandom);
        bus.b       = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), is_mul(ctl) ? 64'(W + 1) : 64'(1));
    check("busy_cycles", 64'(nbusy), is_mul(ctl) ? 64'(W) : 64'(0));
    check("done", 64'(bus.done), 64'(1));
    if (bus.done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y", 64'(bus.y), 64'(e[W-1:0]));
      check("overflow", 64'(bus.overflow), 64'(e[W]));
      check("carry_out", 64'(bus.carry_out), 64'(e[W+1]));
      check("err", 64'(bus.err), 64'(e[W+2]));
      check("zero", 64'(bus.zero), 64'(e[W-1:0] == '0));
      check("busy_at_done", 64'(bus.busy), 64'(0));
    end else begin
      exp_q.delete();
    end
  endtask

  // One idle cycle after a done: pulse must be gone and y must hold.
  task automatic idle_check();
    logic [W-1:0] y_hold;
    y_hold = bus.y;
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'(0));
    check("y_hold", 64'(bus.y), 64'(y_hold));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] legal_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                4'b0111, 4'b1100, 4'b1000, 4'b1001};

  initial begin
    logic [3:0] ctl;
    bus.start   = 1'b0;
    bus.alu_ctl = 4'b0000;
    bus.a       = '0;
    bus.b       = '0;
    rst = 1'b1;
    #12;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_y", 64'(bus.y), 64'(0));
    check("rst_zero", 64'(bus.zero), 64'(1));
    check("rst_err", 64'(bus.err), 64'(0));
    check("rst_carry", 64'(bus.carry_out), 64'(0));
    check("rst_ovf", 64'(bus.overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // logic ops back to back, then arithmetic
    run_op(4'b0000, 4'b1101, 4'b1010, 1'b0);
    check("spec_and", 64'(bus.y), 64'(4'b1000));
    run_op(4'b0001, 4'b1101, 4'b1010, 1'b0);
    check("spec_or", 64'(bus.y), 64'(4'b1111));
    run_op(4'b1100, 4'b1101, 4'b1010, 1'b0);
    check("spec_nor_zero", 64'(bus.zero), 64'(1));
    run_op(4'b0010, 4'b1101, 4'b1010, 1'b0);
    check("spec_add", 64'({bus.carry_out, bus.overflow, bus.y}), 64'({1'b1, 1'b1, 4'b0111}));
    run_op(4'b0110, 4'b1101, 4'b1010, 1'b0);
    check("spec_sub", 64'({bus.carry_out, bus.overflow, bus.y}), 64'({1'b1, 1'b0, 4'b0011}));
    run_op(4'b0111, 4'b1101, 4'b1010, 1'b0);
    run_op(4'b0111, 4'b1010, 4'b1101, 1'b0);
    check("spec_slt", 64'(bus.y), 64'(4'b0001));
    run_op(4'b0111, 4'b0111, 4'b1000, 1'b0);
    idle_check();

    // multiply with an ignored mid-flight start
    run_op(4'b1000, 4'b1101, 4'b1010, 1'b1);
    check("spec_mul", 64'(bus.y), 64'(4'b0010));
    idle_check();
    run_op(4'b1001, 4'b1101, 4'b1010, 1'b1);
    check("spec_mulhu", 64'(bus.y), 64'(4'b1000));
    idle_check();

    // reset mid-multiply
    bus.start = 1'b1; bus.alu_ctl = 4'b1000; bus.a = 4'b1111; bus.b = 4'b1111;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_before_rst", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_y", 64'(bus.y), 64'(0));
    check("midrst_zero", 64'(bus.zero), 64'(1));
    check("midrst_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("no_done_after_rst", 64'(bus.done), 64'(0));
    end
    run_op(4'b0010, 4'b0001, 4'b0001, 1'b0);
    check("spec_add_after_rst", 64'(bus.y), 64'(4'b0010));

    // illegal op, then MUL followed by ADD issued in the done cycle
    run_op(4'b0101, 4'b1101, 4'b1010, 1'b0);
    check("spec_illegal", 64'({bus.err, bus.zero, bus.y}), 64'({1'b1, 1'b1, 4'b0000}));
    idle_check();
    run_op(4'b1000, 4'b0011, 4'b0101, 1'b0);
    run_op(4'b0010, 4'b0011, 4'b0100, 1'b0);
    check("b2b_add", 64'(bus.y), 64'(4'b0111));
    idle_check();

    // random traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) ctl = 4'($urandom_range(0, 15));
      else ctl = legal_ops[$urandom_range(0, 7)];
      run_op(ctl, W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
